usb_sniffer_cfg_regs: RTL

AXI4-Lite slave register bank attached to the peripheral0 port of the sniffer's AXI address-split stage, i.e. the 0x8000_0000 region. It holds capture configuration, exposes capture status, and aggregates sticky interrupt sources into one interrupt line. It supports one outstanding write and one outstanding read, each with a registered response.

---
 rtl/usb_sniffer_cfg_regs.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/usb_sniffer_cfg_regs.sv
// AXI4-Lite config/status/IRQ register bank for the sniffer peripheral0 (0x8000_0000) region.
// Optional TIMESTAMP counter at 0x14 is built when USB_SNIFFER_CFG_TIMESTAMP_EN is defined.
module usb_sniffer_cfg_regs (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport_awvalid_i,
  output logic        inport_awready_o,
  input  logic [31:0] inport_awaddr_i,
  input  logic        inport_wvalid_i,
  output logic        inport_wready_o,
  input  logic [31:0] inport_wdata_i,
  input  logic [3:0]  inport_wstrb_i,
  output logic        inport_bvalid_o,
  input  logic        inport_bready_i,
  output logic [1:0]  inport_bresp_o,
  input  logic        inport_arvalid_i,
  output logic        inport_arready_o,
  input  logic [31:0] inport_araddr_i,
  output logic        inport_rvalid_o,
  input  logic        inport_rready_i,
  output logic [31:0] inport_rdata_o,
  output logic [1:0]  inport_rresp_o,
  input  logic [31:0] status_i,
  input  logic [7:0]  irq_set_i,
  output logic [7:0]  cfg_ctrl_o,
  output logic [31:0] cfg_match_o,
  output logic        irq_o
);
  localparam logic [5:0] OFF_CTRL     = 6'h00;
  localparam logic [5:0] OFF_MATCH    = 6'h01;
  localparam logic [5:0] OFF_STATUS   = 6'h02;
  localparam logic [5:0] OFF_IRQ_STS  = 6'h03;
  localparam logic [5:0] OFF_IRQ_MASK = 6'h04;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  logic        aw_held, w_held;
  logic [5:0]  aw_off_q;
  logic [31:0] w_dat_q;
  logic [3:0]  w_strb_q;
  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic [7:0]  ctrl_q, irq_sts_q, irq_mask_q;
  logic [31:0] match_q;
  logic        irq_q;

  logic        aw_fire, w_fire, ar_fire, commit;
  logic [5:0]  wr_off;
  logic [31:0] wr_dat;
  logic [3:0]  wr_strb;
  logic        wr_ctrl, wr_match, wr_sts, wr_mask, wr_err;
  logic [31:0] rd_dat;
  logic        rd_err;
  logic [7:0]  irq_clr;
`ifdef USB_SNIFFER_CFG_TIMESTAMP_EN
  localparam logic [5:0] OFF_TS = 6'h05;
  logic        wr_ts;
  logic [31:0] ts_q;
`endif

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

  // Readies depend only on state (and reset), never on the valids.
  assign inport_awready_o = rst_i & ~aw_held & ~bvalid_q;
  assign inport_wready_o  = rst_i & ~w_held & ~bvalid_q;
  assign inport_arready_o = rst_i & ~rvalid_q;

  assign aw_fire = inport_awvalid_i & inport_awready_o;
  assign w_fire  = inport_wvalid_i & inport_wready_o;
  assign ar_fire = inport_arvalid_i & inport_arready_o;
  assign commit  = (aw_held | aw_fire) & (w_held | w_fire);

  assign wr_off  = aw_held ? aw_off_q : inport_awaddr_i[7:2];
  assign wr_dat  = w_held ? w_dat_q : inport_wdata_i;
  assign wr_strb = w_held ? w_strb_q : inport_wstrb_i;

  always_comb begin
    wr_ctrl  = 1'b0;
    wr_match = 1'b0;
    wr_sts   = 1'b0;
    wr_mask  = 1'b0;
    wr_err   = 1'b0;
`ifdef USB_SNIFFER_CFG_TIMESTAMP_EN
    wr_ts    = 1'b0;
`endif
    if (commit) begin
      case (wr_off)
        OFF_CTRL:     wr_ctrl  = 1'b1;
        OFF_MATCH:    wr_match = 1'b1;
        OFF_STATUS:   ;
        OFF_IRQ_STS:  wr_sts   = 1'b1;
        OFF_IRQ_MASK: wr_mask  = 1'b1;
`ifdef USB_SNIFFER_CFG_TIMESTAMP_EN
        OFF_TS:       wr_ts    = 1'b1;
`endif
        default:      wr_err   = 1'b1;
      endcase
    end
  end

  always_comb begin
    rd_dat = '0;
    rd_err = 1'b0;
    case (inport_araddr_i[7:2])
      OFF_CTRL:     rd_dat = {24'h0, ctrl_q};
      OFF_MATCH:    rd_dat = match_q;
      OFF_STATUS:   rd_dat = status_i;
      OFF_IRQ_STS:  rd_dat = {24'h0, irq_sts_q};
      OFF_IRQ_MASK: rd_dat = {24'h0, irq_mask_q};
`ifdef USB_SNIFFER_CFG_TIMESTAMP_EN
      OFF_TS:       rd_dat = ts_q;
`endif
      default:      rd_err = 1'b1;
    endcase
  end

  // A set pulse in the same cycle as its W1C wins because it is OR-ed in after the clear.
  assign irq_clr = (wr_sts && wr_strb[0]) ? wr_dat[7:0] : 8'h00;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_off_q   <= '0;
      w_dat_q    <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      ctrl_q     <= '0;
      match_q    <= '0;
      irq_sts_q  <= '0;
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_fire) begin
          aw_held  <= 1'b1;
          aw_off_q <= inport_awaddr_i[7:2];
        end
        if (w_fire) begin
          w_held   <= 1'b1;
          w_dat_q  <= inport_wdata_i;
          w_strb_q <= inport_wstrb_i;
        end
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (inport_bready_i) begin
        bvalid_q <= 1'b0;
      end
      if (ar_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_dat;
        rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (inport_rready_i) begin
        rvalid_q <= 1'b0;
      end
      if (wr_ctrl && wr_strb[0]) ctrl_q <= wr_dat[7:0];
      if (wr_match) match_q <= apply_strb(match_q, wr_dat, wr_strb);
      if (wr_mask && wr_strb[0]) irq_mask_q <= wr_dat[7:0];
      irq_sts_q <= (irq_sts_q & ~irq_clr) | irq_set_i;
      irq_q     <= |(irq_sts_q & irq_mask_q);
    end
  end

`ifdef USB_SNIFFER_CFG_TIMESTAMP_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)     ts_q <= '0;
    else if (wr_ts) ts_q <= apply_strb(ts_q, wr_dat, wr_strb);
    else            ts_q <= ts_q + 32'd1;
  end
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{inport_awaddr_i[31:8], inport_awaddr_i[1:0],
                              inport_araddr_i[31:8], inport_araddr_i[1:0]};

  assign inport_bvalid_o = bvalid_q;
  assign inport_bresp_o  = bresp_q;
  assign inport_rvalid_o = rvalid_q;
  assign inport_rdata_o  = rdata_q;
  assign inport_rresp_o  = rresp_q;
  assign cfg_ctrl_o      = ctrl_q;
  assign cfg_match_o     = match_q;
  assign irq_o           = irq_q;
endmodule
